pc_ctrl: RTL and testbench

- Fetch-stage sequencer that owns the PC update decision: selects next-PC source and drives the PC write enable plus IF/ID and ID/EX control.
- Arbitrates the redirect requests (exception, branch, jump) against stalls (load-use hazard, instruction-memory wait, halt).
- Sits between the pc register, the hazard unit, branch/jump resolution in ID, and the instruction-memory port.

---
 rtl/pc_ctrl_pkg.sv | 27 ++
 rtl/pc_ctrl_if.sv | 36 +++
 rtl/pc_ctrl_redirect_pend.sv | 49 ++++
 rtl/pc_ctrl.sv | 147 ++++++++++++++
 tb/tb_pc_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-stage PC sequencer: FSM states, redirect sources
// and default vectors.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Encoding doubles as priority: higher value wins.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_EXC    = 2'd3
  } src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

  function automatic logic src_ge(input src_e a, input src_e b);
    return (a >= b);
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Bus between the PC sequencer and its neighbours (pc register, hazard unit,
// ID-stage resolution, instruction memory).
interface pc_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      pc_cur;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic             exc;
  logic             load_use;
  logic             halt;
  logic             imem_ready;
  logic [31:0]      pc_next;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             imem_req;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  pc_cur, branch_taken, branch_target, jump, jump_target,
           exc, load_use, halt, imem_ready,
    output pc_next, pc_write, ifid_write, ifid_flush, idex_flush,
           imem_req, stall_cnt
  );

  modport master (
    output pc_cur, branch_taken, branch_target, jump, jump_target,
           exc, load_use, halt, imem_ready,
    input  pc_next, pc_write, ifid_write, ifid_flush, idex_flush,
           imem_req, stall_cnt
  );
endinterface

// File: rtl/pc_ctrl_redirect_pend.sv
// Holds a redirect that arrived while fetch could not act on it; a newer
// request of equal or higher priority replaces the held one.
module pc_redirect_pend
  import pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  src_e        src_in,
  input  logic [31:0] target_in,
  output logic        pend_valid,
  output src_e        pend_src,
  output logic [31:0] pend_target
);
  logic        valid_q, valid_d;
  src_e        src_q, src_d;
  logic [31:0] target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    src_d    = src_q;
    target_d = target_q;
    if (clear) begin
      valid_d = 1'b0;
      src_d   = SRC_NONE;
    end else if (capture && (src_in != SRC_NONE) && src_ge(src_in, src_q)) begin
      valid_d  = 1'b1;
      src_d    = src_in;
      target_d = target_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      src_q    <= SRC_NONE;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      src_q    <= src_d;
      target_q <= target_d;
    end
  end

  assign pend_valid  = valid_q;
  assign pend_src    = src_q;
  assign pend_target = target_q;
endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage sequencer: picks the next-PC source and drives PC / IF/ID /
// ID/EX control, arbitrating redirects against stalls.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int unsigned CNT_W     = 16
) (
  input logic       clk,
  input logic       reset,
  pc_ctrl_if.slave  bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  src_e        new_src, eff_src, pend_src;
  logic [31:0] new_target, eff_target, pend_target, pc_seq;
  logic        pend_valid, capture, clear;
  logic [31:0] pc_next;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, imem_req;

  assign pc_seq = bus.pc_cur + 32'd4;

  always_comb begin
    new_src    = SRC_NONE;
    new_target = '0;
    if (bus.exc) begin
      new_src    = SRC_EXC;
      new_target = EXC_VEC;
    end else if (bus.branch_taken) begin
      new_src    = SRC_BRANCH;
      new_target = bus.branch_target;
    end else if (bus.jump) begin
      new_src    = SRC_JUMP;
      new_target = bus.jump_target;
    end
  end

  // A fresh request beats the held one only at equal or higher priority.
  always_comb begin
    eff_src    = SRC_NONE;
    eff_target = '0;
    if ((new_src != SRC_NONE) && (!pend_valid || src_ge(new_src, pend_src))) begin
      eff_src    = new_src;
      eff_target = new_target;
    end else if (pend_valid) begin
      eff_src    = pend_src;
      eff_target = pend_target;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_next    = pc_seq;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    imem_req   = 1'b0;
    capture    = 1'b0;
    clear      = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        pc_next    = RESET_VEC;
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN, ST_WAIT: begin
        imem_req = 1'b1;
        if (!bus.imem_ready) begin
          capture = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
          clear   = 1'b1;
          if (eff_src != SRC_NONE) begin
            pc_next    = eff_target;
            pc_write   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = (eff_src == SRC_EXC);
          end else if (bus.load_use && (state_q == ST_RUN)) begin
            idex_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        if (bus.halt) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        capture = 1'b1;
        state_d = bus.halt ? ST_HALTED : ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
    // Outputs are combinational, so they must also reflect reset immediately.
    if (!reset) begin
      pc_next    = RESET_VEC;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b0;
      imem_req   = 1'b0;
      capture    = 1'b0;
      clear      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == ST_RUN) || (state_q == ST_WAIT)) && !pc_write &&
        (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pc_redirect_pend u_pend (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .clear       (clear),
    .src_in      (new_src),
    .target_in   (new_target),
    .pend_valid  (pend_valid),
    .pend_src    (pend_src),
    .pend_target (pend_target)
  );

  assign bus.pc_next    = pc_next;
  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.imem_req   = imem_req;
  assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: inputs change on the falling edge, outputs are
// checked 1 time unit later against hand-computed values.
module tb_pc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  pc_ctrl_if #(.CNT_W(16)) bus ();

  pc_ctrl #(
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (32'h0000_0080),
    .CNT_W     (16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.exc           = 1'b0;
    bus.load_use      = 1'b0;
    bus.halt          = 1'b0;
  endtask

  initial begin
    bus.pc_cur     = '0;
    bus.imem_ready = 1'b1;
    quiet();

    // Reset held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_next",    bus.pc_next, 32'h0);
    chk("rst_pc_write",   32'(bus.pc_write), 32'd0);
    chk("rst_ifid_write", 32'(bus.ifid_write), 32'd0);
    chk("rst_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    chk("rst_idex_flush", 32'(bus.idex_flush), 32'd0);
    chk("rst_imem_req",   32'(bus.imem_req), 32'd0);
    chk("rst_stall_cnt",  32'(bus.stall_cnt), 32'd0);

    // BOOT cycle
    @(negedge clk); reset = 1'b1; #1;
    chk("boot_pc_next",  bus.pc_next, 32'h0);
    chk("boot_pc_write", 32'(bus.pc_write), 32'd1);

    // Sequential fetch 4, 8, 12
    @(negedge clk); bus.pc_cur = 32'h0; #1;
    chk("seq0_pc_next",  bus.pc_next, 32'h4);
    chk("seq0_imem_req", 32'(bus.imem_req), 32'd1);
    chk("seq0_ifid_wr",  32'(bus.ifid_write), 32'd1);
    @(negedge clk); bus.pc_cur = 32'h4; #1;
    chk("seq1_pc_next", bus.pc_next, 32'h8);
    @(negedge clk); bus.pc_cur = 32'h8; #1;
    chk("seq2_pc_next", bus.pc_next, 32'hC);
    chk("seq_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Branch beats jump; redirect beats load_use (no bubble)
    @(negedge clk);
    bus.pc_cur = 32'h40;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h100;
    bus.jump = 1'b1; bus.jump_target = 32'h200;
    bus.load_use = 1'b1;
    #1;
    chk("br_pc_next",    bus.pc_next, 32'h100);
    chk("br_pc_write",   32'(bus.pc_write), 32'd1);
    chk("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    chk("br_idex_flush", 32'(bus.idex_flush), 32'd0);

    // Exception beats branch and flushes ID/EX
    @(negedge clk); quiet();
    bus.pc_cur = 32'h100;
    bus.exc = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h500;
    #1;
    chk("exc_pc_next",    bus.pc_next, 32'h80);
    chk("exc_idex_flush", 32'(bus.idex_flush), 32'd1);
    chk("exc_ifid_flush", 32'(bus.ifid_flush), 32'd1);

    // Load-use bubble
    @(negedge clk); quiet();
    bus.pc_cur = 32'h20; bus.load_use = 1'b1; #1;
    chk("lu_pc_write",   32'(bus.pc_write), 32'd0);
    chk("lu_ifid_write", 32'(bus.ifid_write), 32'd0);
    chk("lu_idex_flush", 32'(bus.idex_flush), 32'd1);
    @(negedge clk); bus.load_use = 1'b0; #1;
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("lu_pc_next",   bus.pc_next, 32'h24);

    // imem wait: jump then higher-priority branch while waiting
    @(negedge clk); bus.pc_cur = 32'h24; bus.imem_ready = 1'b0; #1;
    chk("w0_pc_write", 32'(bus.pc_write), 32'd0);
    chk("w0_imem_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk); bus.jump = 1'b1; bus.jump_target = 32'h300; #1;
    chk("w1_pc_write", 32'(bus.pc_write), 32'd0);
    @(negedge clk); quiet(); bus.branch_taken = 1'b1; bus.branch_target = 32'h180; #1;
    chk("w2_pc_write", 32'(bus.pc_write), 32'd0);
    @(negedge clk); quiet(); bus.imem_ready = 1'b1; #1;
    chk("w3_pc_next",    bus.pc_next, 32'h180);
    chk("w3_pc_write",   32'(bus.pc_write), 32'd1);
    chk("w3_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    chk("w3_ifid_write", 32'(bus.ifid_write), 32'd0);
    chk("w3_stall_cnt",  32'(bus.stall_cnt), 32'd4);

    // PC wrap
    @(negedge clk); bus.pc_cur = 32'hFFFF_FFFC; #1;
    chk("wrap_pc_next", bus.pc_next, 32'h0);

    // Halt with a jump arriving while halted
    @(negedge clk); bus.pc_cur = 32'h10; bus.halt = 1'b1; #1;
    chk("h0_pc_next", bus.pc_next, 32'h14);
    @(negedge clk); bus.jump = 1'b1; bus.jump_target = 32'h300; #1;
    chk("h1_imem_req", 32'(bus.imem_req), 32'd0);
    chk("h1_pc_write", 32'(bus.pc_write), 32'd0);
    @(negedge clk); quiet(); #1;
    chk("h2_stall_cnt", 32'(bus.stall_cnt), 32'd4);
    @(negedge clk); bus.pc_cur = 32'h14; #1;
    chk("h3_pc_next",    bus.pc_next, 32'h300);
    chk("h3_ifid_flush", 32'(bus.ifid_flush), 32'd1);

    // Reset in WAIT discards a pending exception
    @(negedge clk); bus.pc_cur = 32'h300; bus.imem_ready = 1'b0; #1;
    chk("r0_pc_write", 32'(bus.pc_write), 32'd0);
    @(negedge clk); bus.exc = 1'b1; #1;
    chk("r1_pc_write", 32'(bus.pc_write), 32'd0);
    @(negedge clk); quiet(); #1;
    chk("r2_stall_cnt", 32'(bus.stall_cnt), 32'd6);
    reset = 1'b0; #1;
    chk("r2_pc_next",    bus.pc_next, 32'h0);
    chk("r2_pc_write",   32'(bus.pc_write), 32'd0);
    chk("r2_ifid_flush", 32'(bus.ifid_flush), 32'd1);
    chk("r2_imem_req",   32'(bus.imem_req), 32'd0);
    chk("r2_stall_rst",  32'(bus.stall_cnt), 32'd0);
    @(negedge clk); reset = 1'b1; bus.imem_ready = 1'b1; #1;
    chk("r3_pc_next",  bus.pc_next, 32'h0);
    chk("r3_pc_write", 32'(bus.pc_write), 32'd1);
    @(negedge clk); bus.pc_cur = 32'h0; #1;
    chk("r4_pc_next",    bus.pc_next, 32'h4);
    chk("r4_ifid_flush", 32'(bus.ifid_flush), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
